// File: rtl/xyz_unit_arbiter_pkg.sv
// Shared definitions for the xyz unit arbiter: FSM state encoding and a
// width helper used to size the requester id and the latency counter.
package xyz_unit_arbiter_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } state_e;

  // ceil(log2(n)) with a floor of 1 so single-value counters still get a bit
  function automatic int unsigned clog2w(input int unsigned n);
    int unsigned w;
    w = 1;
    for (int unsigned i = 1; i < 32; i++) begin
      if ((32'd1 << i) < n) w = i + 1;
    end
    return w;
  endfunction

endpackage

// File: rtl/xyz_unit_arbiter_if.sv
// Requester-side bus of the xyz unit arbiter.
//   req/op_x/op_y/op_z : per-requester request level and operand bits
//   gnt                : one-hot grant pulse
//   rsp_valid/id/data  : one-cycle result pulse tagged with requester id
//   busy               : operation in flight
// master = requester logic, slave = arbiter.
interface xyz_unit_arbiter_if
  import xyz_unit_arbiter_pkg::*;
#(
  parameter int unsigned NREQ = 4,
  parameter int unsigned IDW  = clog2w(NREQ)
);

  logic [NREQ-1:0] req;
  logic [NREQ-1:0] op_x;
  logic [NREQ-1:0] op_y;
  logic [NREQ-1:0] op_z;
  logic [NREQ-1:0] gnt;
  logic            rsp_valid;
  logic [IDW-1:0]  rsp_id;
  logic            rsp_data;
  logic            busy;

  modport master (
    output req, op_x, op_y, op_z,
    input  gnt, rsp_valid, rsp_id, rsp_data, busy
  );

  modport slave (
    input  req, op_x, op_y, op_z,
    output gnt, rsp_valid, rsp_id, rsp_data, busy
  );

endinterface

// File: rtl/xyz_rr_pick.sv
// Combinational rotate-priority picker.
//   req    : request vector
//   ptr    : highest-priority index this round
//   any    : at least one request set
//   idx    : first set index scanning ptr, ptr+1, ... mod NREQ
//   onehot : one-hot of idx (zero when no request)
module xyz_rr_pick
  import xyz_unit_arbiter_pkg::*;
#(
  parameter int unsigned NREQ = 4,
  parameter int unsigned IDW  = clog2w(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  ptr,
  output logic            any_c,
  output logic [IDW-1:0]  idx_c,
  output logic [NREQ-1:0] onehot_c
);

  int unsigned    pos;
  logic [IDW-1:0] pos_w;

  // First hit in rotated order wins; later hits are masked by any_c
  always_comb begin
    any_c    = 1'b0;
    idx_c    = '0;
    onehot_c = '0;
    pos      = 0;
    pos_w    = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      pos   = (32'(ptr) + k) % NREQ;
      pos_w = IDW'(pos);
      if (!any_c && req[pos_w]) begin
        any_c = 1'b1;
        idx_c = pos_w;
      end
    end
    if (any_c) onehot_c = NREQ'(1) << idx_c;
  end

endmodule

// File: rtl/xyz_unit_arbiter.sv
// Round-robin arbiter sharing one 3-input, 1-bit function unit among NREQ
// requesters. The winner's operands are registered onto unit_x/y/z, held for
// LAT cycles, then unit_out is captured and returned with the winner's id.
//   clk, rstn      : clock, synchronous active-low reset
//   bus (slave)    : requester bus (req, op_*, gnt, rsp_*, busy)
//   unit_x/y/z     : registered operands to the shared unit
//   unit_out       : result from the shared unit
module xyz_unit_arbiter
  import xyz_unit_arbiter_pkg::*;
#(
  parameter int unsigned NREQ = 4,
  parameter int unsigned LAT  = 2,
  parameter int unsigned IDW  = clog2w(NREQ)
) (
  input  logic                   clk,
  input  logic                   rstn,
  xyz_unit_arbiter_if.slave      bus,
  output logic                   unit_x,
  output logic                   unit_y,
  output logic                   unit_z,
  input  logic                   unit_out
);

  localparam int unsigned CNTW = clog2w(LAT);

  if (NREQ < 2) begin : g_bad_nreq
    $error("xyz_unit_arbiter: NREQ must be >= 2");
  end
  if (LAT < 1) begin : g_bad_lat
    $error("xyz_unit_arbiter: LAT must be >= 1");
  end

  state_e          state_q,     state_d;
  logic [IDW-1:0]  ptr_q,       ptr_d;
  logic [CNTW-1:0] cnt_q,       cnt_d;
  logic [IDW-1:0]  cur_id_q,    cur_id_d;
  logic [NREQ-1:0] gnt_q,       gnt_d;
  logic            unit_x_q,    unit_x_d;
  logic            unit_y_q,    unit_y_d;
  logic            unit_z_q,    unit_z_d;
  logic            rsp_valid_q, rsp_valid_d;
  logic [IDW-1:0]  rsp_id_q,    rsp_id_d;
  logic            rsp_data_q,  rsp_data_d;
  logic            busy_q,      busy_d;

  logic            pick_any_c;
  logic [IDW-1:0]  pick_idx_c;
  logic [NREQ-1:0] pick_onehot_c;

  xyz_rr_pick #(
    .NREQ (NREQ),
    .IDW  (IDW)
  ) u_pick (
    .req      (bus.req),
    .ptr      (ptr_q),
    .any_c    (pick_any_c),
    .idx_c    (pick_idx_c),
    .onehot_c (pick_onehot_c)
  );

  // Next-state and registered-output logic
  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    cnt_d       = cnt_q;
    cur_id_d    = cur_id_q;
    gnt_d       = '0;
    unit_x_d    = unit_x_q;
    unit_y_d    = unit_y_q;
    unit_z_d    = unit_z_q;
    rsp_valid_d = 1'b0;
    rsp_id_d    = rsp_id_q;
    rsp_data_d  = rsp_data_q;
    busy_d      = busy_q;
    unique case (state_q)
      ST_IDLE: begin
        if (pick_any_c) begin
          gnt_d    = pick_onehot_c;
          unit_x_d = bus.op_x[pick_idx_c];
          unit_y_d = bus.op_y[pick_idx_c];
          unit_z_d = bus.op_z[pick_idx_c];
          cur_id_d = pick_idx_c;
          // Explicit wrap keeps non-power-of-two NREQ correct
          ptr_d    = (pick_idx_c == IDW'(NREQ - 1)) ? '0 : pick_idx_c + IDW'(1);
          cnt_d    = '0;
          busy_d   = 1'b1;
          state_d  = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (cnt_q == CNTW'(LAT - 1)) begin
          rsp_data_d  = unit_out;
          rsp_id_d    = cur_id_q;
          rsp_valid_d = 1'b1;
          busy_d      = 1'b0;
          cnt_d       = '0;
          state_d     = ST_IDLE;
        end else begin
          cnt_d = cnt_q + CNTW'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State register with synchronous reset
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q     <= ST_IDLE;
      ptr_q       <= '0;
      cnt_q       <= '0;
      cur_id_q    <= '0;
      gnt_q       <= '0;
      unit_x_q    <= 1'b0;
      unit_y_q    <= 1'b0;
      unit_z_q    <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= '0;
      rsp_data_q  <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      cnt_q       <= cnt_d;
      cur_id_q    <= cur_id_d;
      gnt_q       <= gnt_d;
      unit_x_q    <= unit_x_d;
      unit_y_q    <= unit_y_d;
      unit_z_q    <= unit_z_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_id_q    <= rsp_id_d;
      rsp_data_q  <= rsp_data_d;
      busy_q      <= busy_d;
    end
  end

  assign bus.gnt       = gnt_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_id    = rsp_id_q;
  assign bus.rsp_data  = rsp_data_q;
  assign bus.busy      = busy_q;
  assign unit_x        = unit_x_q;
  assign unit_y        = unit_y_q;
  assign unit_z        = unit_z_q;

endmodule

// File: tb/tb_xyz_unit_arbiter.sv
// Directed bench for xyz_unit_arbiter (NREQ=4, LAT=2) with an AND-OR unit stub.
module tb_xyz_unit_arbiter;

  localparam int unsigned NREQ = 4;
  localparam int unsigned LAT  = 2;
  localparam int unsigned IDW  = 2;

  logic clk;
  logic rstn;
  logic unit_x, unit_y, unit_z, unit_out;

  int n_checks;
  int n_fail;

  xyz_unit_arbiter_if #(.NREQ(NREQ), .IDW(IDW)) bus ();

  xyz_unit_arbiter #(
    .NREQ (NREQ),
    .LAT  (LAT),
    .IDW  (IDW)
  ) dut (
    .clk      (clk),
    .rstn     (rstn),
    .bus      (bus),
    .unit_x   (unit_x),
    .unit_y   (unit_y),
    .unit_z   (unit_z),
    .unit_out (unit_out)
  );

  // Shared unit stub
  assign unit_out = (unit_x & unit_y) | unit_z;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  // Advance one edge and settle just after it
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Expected round-robin winners with req=1111 from ptr=0
  logic [NREQ-1:0] rr_gnt [5];
  logic [IDW-1:0]  rr_id  [5];
  logic            rr_dat [5];
  logic [NREQ-1:0] wr_gnt [3];
  logic [IDW-1:0]  wr_id  [3];

  initial begin
    #200000;
    $display("FAIL watchdog obs=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rr_gnt = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    rr_id  = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    // op_z = 1010, x=y=0 -> stub returns z bit
    rr_dat = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    wr_gnt = '{4'b0001, 4'b0010, 4'b0001};
    wr_id  = '{2'd0, 2'd1, 2'd0};

    rstn     = 1'b0;
    bus.req  = '0;
    bus.op_x = '0;
    bus.op_y = '0;
    bus.op_z = '0;

    // Reset
    step();
    step();
    chk("rst_gnt",   32'(bus.gnt), 32'h0);
    chk("rst_ux",    32'(unit_x), 32'h0);
    chk("rst_uy",    32'(unit_y), 32'h0);
    chk("rst_uz",    32'(unit_z), 32'h0);
    chk("rst_rv",    32'(bus.rsp_valid), 32'h0);
    chk("rst_rid",   32'(bus.rsp_id), 32'h0);
    chk("rst_rdat",  32'(bus.rsp_data), 32'h0);
    chk("rst_busy",  32'(bus.busy), 32'h0);
    rstn = 1'b1;
    step();
    chk("idle_gnt",  32'(bus.gnt), 32'h0);
    chk("idle_busy", 32'(bus.busy), 32'h0);

    // Round-robin with all requesters held
    bus.req  = 4'b1111;
    bus.op_z = 4'b1010;
    for (int g = 0; g < 5; g++) begin
      step();
      chk("rr_gnt",  32'(bus.gnt), 32'(rr_gnt[g]));
      chk("rr_busy", 32'(bus.busy), 32'h1);
      step();
      chk("rr_gnt_clr", 32'(bus.gnt), 32'h0);
      chk("rr_rv_early", 32'(bus.rsp_valid), 32'h0);
      if (g == 4) bus.req = '0;
      step();
      chk("rr_rv",   32'(bus.rsp_valid), 32'h1);
      chk("rr_rid",  32'(bus.rsp_id), 32'(rr_id[g]));
      chk("rr_rdat", 32'(bus.rsp_data), 32'(rr_dat[g]));
      chk("rr_idle", 32'(bus.busy), 32'h0);
    end
    step();
    chk("rr_rv_pulse", 32'(bus.rsp_valid), 32'h0);
    chk("rr_no_gnt",   32'(bus.gnt), 32'h0);

    // Single request from requester 2 (ptr=1), stub(1,0,1)=1
    bus.op_x = 4'b0100;
    bus.op_y = 4'b0000;
    bus.op_z = 4'b0100;
    bus.req  = 4'b0100;
    step();
    chk("one_gnt", 32'(bus.gnt), 32'h4);
    chk("one_ux",  32'(unit_x), 32'h1);
    chk("one_uy",  32'(unit_y), 32'h0);
    chk("one_uz",  32'(unit_z), 32'h1);
    bus.req = '0;
    step();
    chk("one_gnt_clr", 32'(bus.gnt), 32'h0);
    chk("one_busy",    32'(bus.busy), 32'h1);
    step();
    chk("one_rv",   32'(bus.rsp_valid), 32'h1);
    chk("one_rid",  32'(bus.rsp_id), 32'h2);
    chk("one_rdat", 32'(bus.rsp_data), 32'h1);
    step();
    chk("one_rv_clr", 32'(bus.rsp_valid), 32'h0);

    // Wrap and skip: ptr=3, req=0011
    bus.op_x = '0;
    bus.op_y = '0;
    bus.op_z = '0;
    bus.req  = 4'b0011;
    for (int g = 0; g < 3; g++) begin
      step();
      chk("wr_gnt", 32'(bus.gnt), 32'(wr_gnt[g]));
      step();
      if (g == 2) bus.req = '0;
      step();
      chk("wr_rid", 32'(bus.rsp_id), 32'(wr_id[g]));
    end
    step();
    chk("wr_no_gnt", 32'(bus.gnt), 32'h0);

    // Operand stability: ptr=1, requester 1 with x=y=1, z=0
    bus.op_x = 4'b0010;
    bus.op_y = 4'b0010;
    bus.op_z = 4'b0000;
    bus.req  = 4'b0010;
    step();
    chk("stab_gnt", 32'(bus.gnt), 32'h2);
    chk("stab_ux0", 32'(unit_x), 32'h1);
    bus.op_x = 4'b0000;
    bus.req  = '0;
    step();
    chk("stab_ux1", 32'(unit_x), 32'h1);
    step();
    chk("stab_rv",   32'(bus.rsp_valid), 32'h1);
    chk("stab_rid",  32'(bus.rsp_id), 32'h1);
    chk("stab_rdat", 32'(bus.rsp_data), 32'h1);
    step();

    // Reset mid-op: ptr=2, grant to requester 2 then reset in WAIT
    bus.req = 4'b0100;
    step();
    chk("mid_gnt", 32'(bus.gnt), 32'h4);
    bus.req = '0;
    rstn    = 1'b0;
    step();
    chk("mid_rv0",   32'(bus.rsp_valid), 32'h0);
    chk("mid_busy0", 32'(bus.busy), 32'h0);
    step();
    chk("mid_rv1",   32'(bus.rsp_valid), 32'h0);
    rstn    = 1'b1;
    bus.req = 4'b1010;
    step();
    // ptr back at 0 -> requester 1 beats requester 3
    chk("mid_gnt_ptr0", 32'(bus.gnt), 32'h2);
    bus.req = '0;
    step();
    step();
    chk("mid_rv_after", 32'(bus.rsp_valid), 32'h1);
    chk("mid_rid_after", 32'(bus.rsp_id), 32'h1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
